decode_scoreboard_rf: RTL and testbench
=======================================

// Module: decode_scoreboard_rf
// PURPOSE
//  Parametrised decode-stage register file with a per-register pending-write scoreboard.
//  Replaces fixed ED/MD index-compare hazard checks with counters, so any pipeline depth is covered.
//  Also provides same-cycle writeback bypass, a CC scoreboard and a branch-wait FSM.
//  Sits between Fetch and Execute; Writeback drives the WB port.
// PARAMETERS
//  NUM_REGS     16  number of scalar architectural registers
//  DATA_W       16  register data width (bits)
//  IDX_W        4   register index width, equals clog2(NUM_REGS)
//  MAX_INFLIGHT 3   max outstanding writes per register/CC; CNT_W = clog2(MAX_INFLIGHT+1)
// PORTS
//  I_CLOCK        in   1       single clock, all state on posedge
//  I_RESET        in   1       synchronous, active-high reset
//  I_ISSUE_VALID  in   1       Fetch presents a valid instruction
//  I_SRC1_IDX     in   IDX_W   source 1 register index
//  I_SRC1_USE     in   1       source 1 is read by this instruction
//  I_SRC2_IDX     in   IDX_W   source 2 register index
//  I_SRC2_USE     in   1       source 2 is read by this instruction
//  I_DEST_IDX     in   IDX_W   destination register index
//  I_DEST_WRITE   in   1       instruction writes I_DEST_IDX
//  I_CC_READ      in   1       instruction reads CC (BRxx)
//  I_CC_WRITE     in   1       instruction writes CC
//  I_IS_BRANCH    in   1       control-flow instruction (BRxx/JMP/JSR/JSRR)
//  I_WB_VALID     in   1       writeback of I_WB_DATA to I_WB_IDX
//  I_WB_IDX       in   IDX_W   writeback register index
//  I_WB_DATA      in   DATA_W  writeback data
//  I_WB_CC_VALID  in   1       writeback of CC
//  I_WB_CC        in   3       CC value {N,Z,P}
//  I_BR_RESOLVE   in   1       branch resolved; pulse, 1 cycle
//  O_ISSUE_READY  out  1       instruction may issue this cycle; combinational
//  O_DE_VALID     out  1       registered: output bundle valid
//  O_SRC1_VALUE   out  DATA_W  registered source 1 value
//  O_SRC2_VALUE   out  DATA_W  registered source 2 value
//  O_CC_VALUE     out  3       registered CC value
//  O_DEP_STALL    out  1       combinational: valid & data/CC hazard
//  O_BRANCH_STALL out  1       registered: FSM in BR_WAIT
//  O_ERR          out  1       sticky: WB to register or CC with zero pending count
// BEHAVIOUR
//  Reset (posedge with I_RESET=1):
//   - RF entries = 0; all pending counters = 0; CC = 0; FSM = IDLE.
//   - O_DE_VALID, O_SRC*_VALUE, O_CC_VALUE, O_BRANCH_STALL and O_ERR = 0.
//   - Reset overrides in-flight issue/WB in the same cycle.
//  Hazard on a source s (USE=1):
//   - pend[s] != 0, unless pend[s]==1 && I_WB_VALID && I_WB_IDX==s; that case is bypassed.
//   - A CC hazard follows the same rule with cc_pend and I_WB_CC_VALID.
//  WAW cap: hazard if I_DEST_WRITE and pend[dest]==MAX_INFLIGHT (the same applies to CC).
//  O_ISSUE_READY = !hazard && state==IDLE. fire = I_ISSUE_VALID && O_ISSUE_READY.
//  O_DEP_STALL = I_ISSUE_VALID && hazard.
//  Read data is the RF value, or I_WB_DATA when the WB index matches in the same cycle (bypass).
//  On fire: O_SRC*/O_CC are captured next posedge and O_DE_VALID=1 (1-cycle latency).
//  With no fire: O_DE_VALID=0 and the data outputs hold.
//  Counters:
//   - fire with DEST_WRITE: +1. WB_VALID: RF[idx] written and -1.
//   - Both on the same index in the same cycle: unchanged.
//   - WB at count 0: RF still written, count stays 0, O_ERR set.
//  FSM IDLE -> BR_WAIT on fire && I_IS_BRANCH.
//  BR_WAIT -> IDLE on I_BR_RESOLVE.
//  In BR_WAIT: O_BRANCH_STALL=1 and O_ISSUE_READY=0. I_BR_RESOLVE in IDLE is ignored.
//  WB and CC writes proceed in every state.
// TESTING
//  - Reset: hold I_RESET 2 cycles -> all outputs 0, O_ISSUE_READY=1 for any hazard-free input.
//  - RAW stall: issue dest R3, then src1=R3 -> O_DEP_STALL=1; WB R3=0x00AA -> same-cycle fire, O_SRC1_VALUE=0x00AA next cycle.
//  - WAW cap: 3 issues to R5 with no WB -> 4th has O_ISSUE_READY=0; one WB R5 -> 4th fires, pend[R5] stays 3.
//  - Same-cycle inc/dec: issue dest R2 while WB R2 (pend=1) -> pend[R2] stays 1, RF[R2] updated.
//  - Branch: CMP (CC_WRITE) then BRZ -> stall until WB_CC=3'b010.
//    BRZ fires, O_CC_VALUE=010, O_BRANCH_STALL=1 until I_BR_RESOLVE, then READY=1.
//  - Error: WB R7 with pend[R7]=0 -> RF[R7] written, O_ERR=1 until reset.

Source files
------------

// File: rtl/decode_scoreboard_rf.sv
// decode_scoreboard_rf
//   Decode-stage register file with a per-register pending-write scoreboard, a
//   CC scoreboard, same-cycle writeback bypass and a branch-wait FSM.
//   Pending counters replace fixed index compares, so any pipeline depth is covered.
// Ports
//   I_CLOCK, I_RESET          clock, synchronous active-high reset
//   I_ISSUE_VALID .. I_IS_BRANCH  instruction presented by Fetch
//   I_WB_*                    register / CC writeback from Writeback stage
//   I_BR_RESOLVE              one-cycle branch resolution pulse
//   O_ISSUE_READY, O_DEP_STALL    combinational issue handshake / hazard flag
//   O_DE_VALID, O_SRC*_VALUE, O_CC_VALUE  registered operand bundle to Execute
//   O_BRANCH_STALL            FSM is waiting for branch resolution
//   O_ERR                     sticky: writeback seen with no pending write
module decode_scoreboard_rf #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic              I_CLOCK,
  input  logic              I_RESET,
  input  logic              I_ISSUE_VALID,
  input  logic [IDX_W-1:0]  I_SRC1_IDX,
  input  logic              I_SRC1_USE,
  input  logic [IDX_W-1:0]  I_SRC2_IDX,
  input  logic              I_SRC2_USE,
  input  logic [IDX_W-1:0]  I_DEST_IDX,
  input  logic              I_DEST_WRITE,
  input  logic              I_CC_READ,
  input  logic              I_CC_WRITE,
  input  logic              I_IS_BRANCH,
  input  logic              I_WB_VALID,
  input  logic [IDX_W-1:0]  I_WB_IDX,
  input  logic [DATA_W-1:0] I_WB_DATA,
  input  logic              I_WB_CC_VALID,
  input  logic [2:0]        I_WB_CC,
  input  logic              I_BR_RESOLVE,
  output logic              O_ISSUE_READY,
  output logic              O_DE_VALID,
  output logic [DATA_W-1:0] O_SRC1_VALUE,
  output logic [DATA_W-1:0] O_SRC2_VALUE,
  output logic [2:0]        O_CC_VALUE,
  output logic              O_DEP_STALL,
  output logic              O_BRANCH_STALL,
  output logic              O_ERR
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StBrWait} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  rf_q [NUM_REGS];
  logic [DATA_W-1:0]  rf_d [NUM_REGS];
  logic [CNT_W-1:0]   pend_q [NUM_REGS];
  logic [CNT_W-1:0]   pend_d [NUM_REGS];
  logic [2:0]         cc_q, cc_d;
  logic [CNT_W-1:0]   cc_pend_q, cc_pend_d;
  logic               err_q, err_d;
  logic               de_valid_q;
  logic [DATA_W-1:0]  src1_q, src2_q;
  logic [2:0]         cc_out_q;

  logic               haz_src1, haz_src2, haz_cc, haz_waw, haz_cc_waw, hazard;
  logic               fire;
  logic [DATA_W-1:0]  src1_rd, src2_rd;
  logic [2:0]         cc_rd;
  logic               inc, dec;

  // A pending count of exactly one that retires this cycle is not a hazard:
  // the writeback data is forwarded instead.
  always_comb begin
    haz_src1 = I_SRC1_USE && (pend_q[I_SRC1_IDX] != '0) &&
               !((pend_q[I_SRC1_IDX] == CntOne) && I_WB_VALID && (I_WB_IDX == I_SRC1_IDX));
    haz_src2 = I_SRC2_USE && (pend_q[I_SRC2_IDX] != '0) &&
               !((pend_q[I_SRC2_IDX] == CntOne) && I_WB_VALID && (I_WB_IDX == I_SRC2_IDX));
    haz_cc   = I_CC_READ && (cc_pend_q != '0) && !((cc_pend_q == CntOne) && I_WB_CC_VALID);
    // WAW cap is checked against the registered count only.
    haz_waw    = I_DEST_WRITE && (pend_q[I_DEST_IDX] == CntMax);
    haz_cc_waw = I_CC_WRITE && (cc_pend_q == CntMax);
    hazard     = haz_src1 || haz_src2 || haz_cc || haz_waw || haz_cc_waw;

    O_ISSUE_READY = !hazard && (state_q == StIdle);
    O_DEP_STALL   = I_ISSUE_VALID && hazard;
    fire          = I_ISSUE_VALID && O_ISSUE_READY;

    src1_rd = (I_WB_VALID && (I_WB_IDX == I_SRC1_IDX)) ? I_WB_DATA : rf_q[I_SRC1_IDX];
    src2_rd = (I_WB_VALID && (I_WB_IDX == I_SRC2_IDX)) ? I_WB_DATA : rf_q[I_SRC2_IDX];
    cc_rd   = I_WB_CC_VALID ? I_WB_CC : cc_q;
  end

  // Register file, scoreboard counters and sticky error.
  always_comb begin
    rf_d      = rf_q;
    pend_d    = pend_q;
    cc_d      = cc_q;
    cc_pend_d = cc_pend_q;
    err_d     = err_q;
    inc       = 1'b0;
    dec       = 1'b0;

    for (int i = 0; i < NUM_REGS; i++) begin
      inc = fire && I_DEST_WRITE && (I_DEST_IDX == IDX_W'(i));
      dec = I_WB_VALID && (I_WB_IDX == IDX_W'(i));
      if (dec) begin
        rf_d[i] = I_WB_DATA;
        if (pend_q[i] == '0) err_d = 1'b1;
      end
      if (inc && !dec) begin
        pend_d[i] = pend_q[i] + CntOne;
      end else if (dec && !inc && (pend_q[i] != '0)) begin
        pend_d[i] = pend_q[i] - CntOne;
      end
    end

    inc = fire && I_CC_WRITE;
    dec = I_WB_CC_VALID;
    if (dec) begin
      cc_d = I_WB_CC;
      if (cc_pend_q == '0) err_d = 1'b1;
    end
    if (inc && !dec) begin
      cc_pend_d = cc_pend_q + CntOne;
    end else if (dec && !inc && (cc_pend_q != '0)) begin
      cc_pend_d = cc_pend_q - CntOne;
    end
  end

  // Branch-wait FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fire && I_IS_BRANCH) state_d = StBrWait;
      StBrWait: if (I_BR_RESOLVE) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state_q    <= StIdle;
      cc_q       <= '0;
      cc_pend_q  <= '0;
      err_q      <= 1'b0;
      de_valid_q <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      cc_out_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i]   <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      pend_q     <= pend_d;
      cc_q       <= cc_d;
      cc_pend_q  <= cc_pend_d;
      err_q      <= err_d;
      de_valid_q <= fire;
      if (fire) begin
        src1_q   <= src1_rd;
        src2_q   <= src2_rd;
        cc_out_q <= cc_rd;
      end
    end
  end

  assign O_DE_VALID     = de_valid_q;
  assign O_SRC1_VALUE   = src1_q;
  assign O_SRC2_VALUE   = src2_q;
  assign O_CC_VALUE     = cc_out_q;
  assign O_BRANCH_STALL = (state_q == StBrWait);
  assign O_ERR          = err_q;

endmodule

// File: tb/tb_decode_scoreboard_rf.sv
module tb_decode_scoreboard_rf;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  src1_idx, src2_idx, dest_idx, wb_idx;
  logic        src1_use, src2_use, dest_write;
  logic        cc_read, cc_write, is_branch;
  logic        wb_valid, wb_cc_valid, br_resolve;
  logic [15:0] wb_data;
  logic [2:0]  wb_cc;
  logic        issue_ready, de_valid, dep_stall, branch_stall, err;
  logic [15:0] src1_value, src2_value;
  logic [2:0]  cc_value;

  int checks = 0;
  int fails  = 0;

  decode_scoreboard_rf #(
    .NUM_REGS    (16),
    .DATA_W      (16),
    .IDX_W       (4),
    .MAX_INFLIGHT(3)
  ) dut (
    .I_CLOCK       (clk),
    .I_RESET       (rst),
    .I_ISSUE_VALID (issue_valid),
    .I_SRC1_IDX    (src1_idx),
    .I_SRC1_USE    (src1_use),
    .I_SRC2_IDX    (src2_idx),
    .I_SRC2_USE    (src2_use),
    .I_DEST_IDX    (dest_idx),
    .I_DEST_WRITE  (dest_write),
    .I_CC_READ     (cc_read),
    .I_CC_WRITE    (cc_write),
    .I_IS_BRANCH   (is_branch),
    .I_WB_VALID    (wb_valid),
    .I_WB_IDX      (wb_idx),
    .I_WB_DATA     (wb_data),
    .I_WB_CC_VALID (wb_cc_valid),
    .I_WB_CC       (wb_cc),
    .I_BR_RESOLVE  (br_resolve),
    .O_ISSUE_READY (issue_ready),
    .O_DE_VALID    (de_valid),
    .O_SRC1_VALUE  (src1_value),
    .O_SRC2_VALUE  (src2_value),
    .O_CC_VALUE    (cc_value),
    .O_DEP_STALL   (dep_stall),
    .O_BRANCH_STALL(branch_stall),
    .O_ERR         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; src1_idx = '0; src1_use = 1'b0; src2_idx = '0; src2_use = 1'b0;
    dest_idx = '0; dest_write = 1'b0; cc_read = 1'b0; cc_write = 1'b0; is_branch = 1'b0;
    wb_valid = 1'b0; wb_idx = '0; wb_data = '0; wb_cc_valid = 1'b0; wb_cc = '0;
    br_resolve = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (de_valid !== 1'b0) begin fails++; $display("FAIL reset_de_valid got %b want 0", de_valid); end
    checks++; if (src1_value !== 16'h0) begin fails++; $display("FAIL reset_src1 got %h want 0000", src1_value); end
    checks++; if (src2_value !== 16'h0) begin fails++; $display("FAIL reset_src2 got %h want 0000", src2_value); end
    checks++; if (cc_value !== 3'b000) begin fails++; $display("FAIL reset_cc got %b want 000", cc_value); end
    checks++; if (branch_stall !== 1'b0) begin fails++; $display("FAIL reset_br_stall got %b want 0", branch_stall); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    src1_use = 1'b1; src1_idx = 4'd1; cc_read = 1'b1; dest_write = 1'b1; dest_idx = 4'd9;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", issue_ready); end
    checks++; if (dep_stall !== 1'b0) begin fails++; $display("FAIL reset_dep_stall got %b want 0", dep_stall); end
    idle_inputs();
  endtask

  task automatic test_raw_stall();
    issue_valid = 1'b1; dest_write = 1'b1; dest_idx = 4'd3;
    tick();
    checks++; if (de_valid !== 1'b1) begin fails++; $display("FAIL raw_issue_valid got %b want 1", de_valid); end
    idle_inputs();
    issue_valid = 1'b1; src1_use = 1'b1; src1_idx = 4'd3;
    #1;
    checks++; if (dep_stall !== 1'b1) begin fails++; $display("FAIL raw_dep_stall got %b want 1", dep_stall); end
    checks++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL raw_ready_low got %b want 0", issue_ready); end
    tick();
    checks++; if (de_valid !== 1'b0) begin fails++; $display("FAIL raw_no_fire got %b want 0", de_valid); end
    wb_valid = 1'b1; wb_idx = 4'd3; wb_data = 16'h00AA;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL raw_bypass_ready got %b want 1", issue_ready); end
    checks++; if (dep_stall !== 1'b0) begin fails++; $display("FAIL raw_bypass_stall got %b want 0", dep_stall); end
    tick();
    checks++; if (de_valid !== 1'b1) begin fails++; $display("FAIL raw_bypass_valid got %b want 1", de_valid); end
    checks++; if (src1_value !== 16'h00AA) begin fails++; $display("FAIL raw_bypass_data got %h want 00aa", src1_value); end
    // Register file now holds the written value and R3 is no longer pending.
    idle_inputs();
    issue_valid = 1'b1; src2_use = 1'b1; src2_idx = 4'd3;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL raw_rf_ready got %b want 1", issue_ready); end
    tick();
    checks++; if (src2_value !== 16'h00AA) begin fails++; $display("FAIL raw_rf_data got %h want 00aa", src2_value); end
    idle_inputs();
  endtask

  task automatic test_waw_cap();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; dest_write = 1'b1; dest_idx = 4'd5;
      #1;
      checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL waw_issue%0d_ready got %b want 1", i, issue_ready); end
      tick();
    end
    #1;
    checks++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL waw_cap_ready got %b want 0", issue_ready); end
    checks++; if (dep_stall !== 1'b1) begin fails++; $display("FAIL waw_cap_stall got %b want 1", dep_stall); end
    tick();
    checks++; if (de_valid !== 1'b0) begin fails++; $display("FAIL waw_cap_no_fire got %b want 0", de_valid); end
    idle_inputs();
    wb_valid = 1'b1; wb_idx = 4'd5; wb_data = 16'h1234;
    tick();
    idle_inputs();
    issue_valid = 1'b1; dest_write = 1'b1; dest_idx = 4'd5;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL waw_after_wb_ready got %b want 1", issue_ready); end
    tick();
    checks++; if (de_valid !== 1'b1) begin fails++; $display("FAIL waw_4th_fire got %b want 1", de_valid); end
    #1;
    // Count is back at the cap.
    checks++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL waw_recap_ready got %b want 0", issue_ready); end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_idx = 4'd5; wb_data = 16'h1235 + 16'(i);
      tick();
    end
    idle_inputs();
    src1_use = 1'b1; src1_idx = 4'd5;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL waw_drained_ready got %b want 1", issue_ready); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL waw_no_err got %b want 0", err); end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    issue_valid = 1'b1; dest_write = 1'b1; dest_idx = 4'd2;
    tick();
    wb_valid = 1'b1; wb_idx = 4'd2; wb_data = 16'h5555;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL same_ready got %b want 1", issue_ready); end
    tick();
    idle_inputs();
    issue_valid = 1'b1; src1_use = 1'b1; src1_idx = 4'd2;
    #1;
    checks++; if (dep_stall !== 1'b1) begin fails++; $display("FAIL same_pend1_stall got %b want 1", dep_stall); end
    wb_valid = 1'b1; wb_idx = 4'd2; wb_data = 16'h6666;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL same_bypass_ready got %b want 1", issue_ready); end
    tick();
    checks++; if (src1_value !== 16'h6666) begin fails++; $display("FAIL same_bypass_data got %h want 6666", src1_value); end
    idle_inputs();
    issue_valid = 1'b1; src2_use = 1'b1; src2_idx = 4'd2;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL same_drained_ready got %b want 1", issue_ready); end
    tick();
    checks++; if (src2_value !== 16'h6666) begin fails++; $display("FAIL same_rf_data got %h want 6666", src2_value); end
    idle_inputs();
  endtask

  task automatic test_branch();
    issue_valid = 1'b1; cc_write = 1'b1;
    tick();
    idle_inputs();
    issue_valid = 1'b1; cc_read = 1'b1; is_branch = 1'b1;
    #1;
    checks++; if (dep_stall !== 1'b1) begin fails++; $display("FAIL br_cc_stall got %b want 1", dep_stall); end
    tick();
    checks++; if (de_valid !== 1'b0) begin fails++; $display("FAIL br_no_fire got %b want 0", de_valid); end
    wb_cc_valid = 1'b1; wb_cc = 3'b010;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL br_cc_bypass_ready got %b want 1", issue_ready); end
    tick();
    checks++; if (de_valid !== 1'b1) begin fails++; $display("FAIL br_fire got %b want 1", de_valid); end
    checks++; if (cc_value !== 3'b010) begin fails++; $display("FAIL br_cc_value got %b want 010", cc_value); end
    checks++; if (branch_stall !== 1'b1) begin fails++; $display("FAIL br_stall_set got %b want 1", branch_stall); end
    idle_inputs();
    issue_valid = 1'b1;
    #1;
    checks++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL br_wait_ready got %b want 0", issue_ready); end
    checks++; if (dep_stall !== 1'b0) begin fails++; $display("FAIL br_wait_dep got %b want 0", dep_stall); end
    tick();
    checks++; if (de_valid !== 1'b0) begin fails++; $display("FAIL br_wait_no_fire got %b want 0", de_valid); end
    checks++; if (branch_stall !== 1'b1) begin fails++; $display("FAIL br_stall_hold got %b want 1", branch_stall); end
    idle_inputs();
    br_resolve = 1'b1;
    tick();
    br_resolve = 1'b0;
    checks++; if (branch_stall !== 1'b0) begin fails++; $display("FAIL br_resolved got %b want 0", branch_stall); end
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL br_resolved_ready got %b want 1", issue_ready); end
    br_resolve = 1'b1;
    tick();
    br_resolve = 1'b0;
    checks++; if (branch_stall !== 1'b0) begin fails++; $display("FAIL br_idle_resolve got %b want 0", branch_stall); end
    // Stored CC is read from the register once nothing is pending.
    issue_valid = 1'b1; cc_read = 1'b1;
    tick();
    checks++; if (cc_value !== 3'b010) begin fails++; $display("FAIL br_cc_stored got %b want 010", cc_value); end
    idle_inputs();
  endtask

  task automatic test_error();
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_before got %b want 0", err); end
    wb_valid = 1'b1; wb_idx = 4'd7; wb_data = 16'h0777;
    tick();
    idle_inputs();
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", err); end
    issue_valid = 1'b1; src1_use = 1'b1; src1_idx = 4'd7;
    tick();
    idle_inputs();
    checks++; if (src1_value !== 16'h0777) begin fails++; $display("FAIL err_rf_written got %h want 0777", src1_value); end
    tick();
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_cleared got %b want 0", err); end
    checks++; if (src1_value !== 16'h0) begin fails++; $display("FAIL err_rst_src1 got %h want 0000", src1_value); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_raw_stall();
    test_waw_cap();
    test_same_cycle();
    test_branch();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
